// File: rtl/exc_sched.sv
// Exception/interrupt scheduler between MEM and CP0: synchronizes interrupt lines,
// arbitrates one event per instruction, presents it to CP0 for one cycle, then holds the front end.
module exc_sched #(
    parameter logic [4:0]  EXC_NONE    = 5'h10,
    parameter logic [4:0]  EXC_ERET    = 5'h11,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [5:0]  mem_exc_vec_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] status_i,
    output logic [5:0]  int_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] pc_o,
    output logic        in_delay_o,
    output logic        kill_o,
    output logic        stall_o,
    output logic        busy_o
);

    localparam logic [4:0] EXC_INT   = 5'h00;
    localparam logic [4:0] EXC_ADEL  = 5'h04;
    localparam logic [4:0] EXC_RI    = 5'h0A;
    localparam logic [4:0] EXC_OV    = 5'h0C;
    localparam logic [4:0] EXC_SYS   = 5'h08;
    localparam logic [4:0] EXC_BREAK = 5'h09;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Lowest set flag wins; bit 0 has the highest priority.
    function automatic logic [4:0] exc_pick(input logic [5:0] vec);
        logic [4:0] code;
        casez (vec)
            6'b?????1: code = EXC_ADEL;
            6'b????10: code = EXC_RI;
            6'b???100: code = EXC_OV;
            6'b??1000: code = EXC_SYS;
            6'b?10000: code = EXC_BREAK;
            6'b100000: code = EXC_ERET;
            default:   code = EXC_NONE;
        endcase
        return code;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        dly_q, dly_d;
    logic [5:0]  sync1_q;
    logic [5:0]  int_q;

    logic        int_req_s;
    logic        evt_s;
    logic [4:0]  evt_code_s;
    logic        unused_status_s;

    assign unused_status_s = ^{status_i[31:16], status_i[9:2]};

    // Two-flop synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            sync1_q <= 6'b000000;
            int_q   <= 6'b000000;
        end else begin
            sync1_q <= int_i;
            int_q   <= sync1_q;
        end
    end

    assign int_o = int_q;

    assign int_req_s  = status_i[0] & ~status_i[1] & (|(int_q & status_i[15:10]));
    assign evt_s      = mem_valid_i & (int_req_s | (|mem_exc_vec_i));
    assign evt_code_s = int_req_s ? EXC_INT : exc_pick(mem_exc_vec_i);

    // State, hold counter and captured event registers.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            code_q  <= EXC_NONE;
            pc_q    <= 32'h0000_0000;
            dly_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic and CP0-facing outputs; inputs are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        pc_d       = pc_q;
        dly_d      = dly_q;
        exccode_o  = EXC_NONE;
        pc_o       = 32'h0000_0000;
        in_delay_o = 1'b0;
        kill_o     = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    kill_o  = 1'b1;
                    code_d  = evt_code_s;
                    pc_d    = mem_pc_i;
                    dly_d   = mem_in_delay_i;
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                kill_o     = 1'b1;
                stall_o    = 1'b1;
                exccode_o  = code_q;
                pc_o       = pc_q;
                in_delay_o = dly_q;
                cnt_d      = HOLD_LOAD;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                kill_o  = 1'b1;
                stall_o = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                // A count of 1 marks the last refetch cycle; <= also recovers from a stray 0.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: stimulus pushes expected CP0 events into a queue,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_exc_sched;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_dly;
    logic [5:0]  mem_vec;
    logic [5:0]  int_in;
    logic [31:0] status;
    logic [5:0]  int_out;
    logic [4:0]  exccode;
    logic [31:0] pc_out;
    logic        dly_out;
    logic        kill;
    logic        stall;
    logic        busy;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] pc;
        logic        dly;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    exc_sched dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .mem_valid_i    (mem_valid),
        .mem_pc_i       (mem_pc),
        .mem_in_delay_i (mem_dly),
        .mem_exc_vec_i  (mem_vec),
        .int_i          (int_in),
        .status_i       (status),
        .int_o          (int_out),
        .exccode_o      (exccode),
        .pc_o           (pc_out),
        .in_delay_o     (dly_out),
        .kill_o         (kill),
        .stall_o        (stall),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next();
    endtask

    task automatic drive(input logic v, input logic [5:0] vec, input logic [31:0] pc, input logic d);
        mem_valid = v;
        mem_vec   = vec;
        mem_pc    = pc;
        mem_dly   = d;
    endtask

    task automatic expect_evt(input logic [4:0] code, input logic [31:0] pc, input logic d);
        exp_t e;
        e.code = code;
        e.pc   = pc;
        e.dly  = d;
        sb.push_back(e);
    endtask

    // Monitor: any non-idle code on the CP0 port must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && exccode !== 5'h10) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {27'd0, exccode}, 32'h10);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_code", {27'd0, exccode}, {27'd0, e.code});
                chk("evt_pc", pc_out, e.pc);
                chk("evt_dly", {31'd0, dly_out}, {31'd0, e.dly});
            end
        end
    end

    initial begin
        rst = 1'b1;
        int_in = 6'd0;
        status = 32'd0;
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("rst_exccode", {27'd0, exccode}, 32'h10);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_dly", {31'd0, dly_out}, 32'd0);
        chk("rst_kill", {31'd0, kill}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_int_o", {26'd0, int_out}, 32'd0);
        next();
        rst = 1'b0;
        idle(2);

        // OV alone: kill same cycle, FIRE next, 3 cycles of stall.
        drive(1'b1, 6'b000100, 32'hBFC00100, 1'b0);
        expect_evt(5'h0C, 32'hBFC00100, 1'b0);
        @(negedge clk);
        chk("ov_kill", {31'd0, kill}, 32'd1);
        chk("ov_stall_detect", {31'd0, stall}, 32'd0);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("ov_stall_fire", {31'd0, stall}, 32'd1);
        next();
        @(negedge clk);
        chk("ov_stall_hold1", {31'd0, stall}, 32'd1);
        next();
        @(negedge clk);
        chk("ov_stall_hold2", {31'd0, stall}, 32'd1);
        chk("ov_kill_hold2", {31'd0, kill}, 32'd1);
        next();
        @(negedge clk);
        chk("ov_stall_idle", {31'd0, stall}, 32'd0);
        chk("ov_busy_idle", {31'd0, busy}, 32'd0);
        chk("ov_kill_idle", {31'd0, kill}, 32'd0);
        next();

        // Priority: RI beats SYS and BREAK; delay-slot flag forwarded.
        drive(1'b1, 6'b011010, 32'h0000_0080, 1'b1);
        expect_evt(5'h0A, 32'h0000_0080, 1'b1);
        @(negedge clk);
        chk("pri_kill", {31'd0, kill}, 32'd1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        idle(4);

        // OV together with SYS resolves to OV.
        drive(1'b1, 6'b001100, 32'h0000_0044, 1'b1);
        expect_evt(5'h0C, 32'h0000_0044, 1'b1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        idle(4);

        // Enabled interrupt: two synchronizer edges, then it beats SYS.
        status = 32'h0000_1001;
        int_in = 6'b000100;
        @(negedge clk);
        chk("int_sync0", {26'd0, int_out}, 32'd0);
        next();
        @(negedge clk);
        chk("int_sync1", {26'd0, int_out}, 32'd0);
        next();
        drive(1'b1, 6'b001000, 32'h0000_0100, 1'b0);
        expect_evt(5'h00, 32'h0000_0100, 1'b0);
        @(negedge clk);
        chk("int_sync2", {26'd0, int_out}, 32'h04);
        chk("int_kill", {31'd0, kill}, 32'd1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        int_in = 6'd0;
        @(negedge clk);
        chk("int_stall_fire", {31'd0, stall}, 32'd1);
        idle(5);

        // EXL set: interrupt must be ignored.
        status = 32'h0000_1003;
        int_in = 6'b000100;
        drive(1'b1, 6'd0, 32'h0000_0200, 1'b0);
        repeat (4) begin
            next();
            @(negedge clk);
            chk("exl_no_kill", {31'd0, kill}, 32'd0);
        end
        int_in = 6'd0;
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        idle(3);

        // Pending interrupt waits across bubbles, fires with the next valid PC.
        status = 32'h0000_1001;
        int_in = 6'b000100;
        idle(2);
        repeat (4) begin
            @(negedge clk);
            chk("bubble_code", {27'd0, exccode}, 32'h10);
            chk("bubble_kill", {31'd0, kill}, 32'd0);
            next();
        end
        drive(1'b1, 6'd0, 32'h0000_2000, 1'b0);
        expect_evt(5'h00, 32'h0000_2000, 1'b0);
        @(negedge clk);
        chk("bubble_kill_valid", {31'd0, kill}, 32'd1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        int_in = 6'd0;
        status = 32'd0;
        idle(5);

        // ERET then SYS held: SYS only taken once back in IDLE.
        drive(1'b1, 6'b100000, 32'h0000_0300, 1'b0);
        expect_evt(5'h11, 32'h0000_0300, 1'b0);
        @(negedge clk);
        chk("eret_kill", {31'd0, kill}, 32'd1);
        repeat (3) begin
            next();
            drive(1'b1, 6'b001000, 32'h0000_0304, 1'b0);
            @(negedge clk);
            chk("eret_busy", {31'd0, busy}, 32'd1);
            chk("eret_kill_busy", {31'd0, kill}, 32'd1);
        end
        next();
        expect_evt(5'h08, 32'h0000_0304, 1'b0);
        @(negedge clk);
        chk("sys_idle_busy", {31'd0, busy}, 32'd0);
        chk("sys_idle_kill", {31'd0, kill}, 32'd1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("sys_fire_stall", {31'd0, stall}, 32'd1);
        idle(4);

        // Asynchronous reset during HOLD.
        int_in = 6'b000001;
        idle(2);
        drive(1'b1, 6'b000100, 32'h0000_0500, 1'b0);
        expect_evt(5'h0C, 32'h0000_0500, 1'b0);
        @(negedge clk);
        chk("arst_int_o_before", {26'd0, int_out}, 32'h01);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        next();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_int_o", {26'd0, int_out}, 32'd0);
        chk("arst_kill", {31'd0, kill}, 32'd0);
        int_in = 6'd0;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_code_after", {27'd0, exccode}, 32'h10);
        next();
        drive(1'b1, 6'b000100, 32'h0000_0600, 1'b0);
        expect_evt(5'h0C, 32'h0000_0600, 1'b0);
        @(negedge clk);
        chk("arst_ov_kill", {31'd0, kill}, 32'd1);
        next();
        drive(1'b0, 6'd0, 32'd0, 1'b0);
        idle(5);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exc_sched.md
# exc_sched

Exception/interrupt scheduler sitting between the MEM stage and the CP0 register file. It synchronizes external interrupt lines, arbitrates among synchronous exceptions, ERET and pending interrupts for the instruction currently in MEM, and presents exactly one event per cycle as `exccode/pc/in_delay` to CP0. After presenting an event it holds the front end for a fixed refetch window.

## Interface
Parameters:
- EXC_NONE, 5'h10, "no event" code driven to CP0
- EXC_ERET, 5'h11, ERET code
- HOLD_CYCLES, 2, cycles in HOLD after FIRE (legal range 1..15)

Ports:
- cpu_clk_50M  in  1  single clock; all state on rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- mem_valid_i  in  1  MEM holds a real (non-bubble) instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delay_i  in  1  MEM instruction is in a delay slot
- mem_exc_vec_i  in  6  event flags, priority bit0 highest: [0] ADEL 5'h04, [1] RI 5'h0A, [2] OV 5'h0C, [3] SYS 5'h08, [4] BREAK 5'h09, [5] ERET
- int_i  in  6  asynchronous hardware interrupt lines
- status_i  in  32  CP0 Status; uses [0] IE, [1] EXL, [15:10] IM
- int_o  out  6  synchronized interrupt lines to CP0 Cause[15:10]
- exccode_o  out  5  event code to CP0
- pc_o  out  32  event PC to CP0
- in_delay_o  out  1  delay-slot flag to CP0
- kill_o  out  1  suppress MEM→WB writeback of the current instruction
- stall_o  out  1  freeze PC/IF
- busy_o  out  1  state != IDLE

## Operation
- Synchronizer: two flops per line, `int_i → s1 → int_o`. Reset clears both.
- int_req = status_i[0] & ~status_i[1] & |(int_o & status_i[15:10]).
- Event detection happens only in IDLE with mem_valid_i=1.
  - int_req wins over every exception bit and produces EXC_INT 5'h00.
  - Otherwise the lowest set bit of mem_exc_vec_i wins.
  - Without mem_valid_i, nothing is taken. A pending interrupt waits, level-sensitive, and is re-evaluated every IDLE cycle.
- kill_o is combinational: 1 in IDLE when an event is detected, else 0. It is also 1 throughout FIRE and HOLD.
- FSM:
  - IDLE: on event, register code to `code_q`, mem_pc_i to `pc_q`, and mem_in_delay_i to `dly_q`; go to FIRE. Otherwise stay.
  - FIRE (1 cycle): exccode_o=code_q, pc_o=pc_q, in_delay_o=dly_q; load hold counter with HOLD_CYCLES; go to HOLD.
  - HOLD: decrement the counter each cycle. When the counter reaches 1, go to IDLE at the next edge.
- Outputs outside FIRE: exccode_o=EXC_NONE, pc_o=0, in_delay_o=0.
- stall_o=1 in FIRE and HOLD, else 0. busy_o has the same value.
- While busy, mem_* and int_req are ignored and nothing is queued.
- Interrupt PC is the MEM instruction PC. That instruction is killed and is not executed.
- ERET uses the same path: code EXC_ERET, pc_o=mem_pc_i. CP0 supplies the return address.

## Timing
- Reset values: state IDLE, counter 0, code_q=EXC_NONE, pc_q=0, dly_q=0, int_o=0, exccode_o=EXC_NONE, pc_o=0, in_delay_o=0, kill_o=0, stall_o=0, busy_o=0.
- Interrupt latency:
  - int_i rises, then int_o is visible 2 edges later.
  - With IDLE, mem_valid_i=1 and enabled, kill_o rises the same cycle.
  - FIRE follows on the next cycle.
- Exception latency: detect in cycle N, FIRE in N+1, HOLD in N+2..N+1+HOLD_CYCLES, IDLE in N+2+HOLD_CYCLES.
- Total busy length is 1+HOLD_CYCLES cycles. Back-to-back events are separated by at least that.
- EXL is set by CP0 after FIRE. status_i is not sampled while busy.
- Reset asserted mid-FIRE or mid-HOLD forces the reset values immediately (asynchronous). The first event after deassertion is evaluated on the first IDLE edge.
- Simultaneous cases:
  - int_req with any exception bit: EXC_INT.
  - OV with SYS: OV.
  - int_req with mem_valid_i=0: wait.

## Test plan
- OV only: mem_vec=6'b000100, pc=0xBFC00100, valid=1 → kill_o=1 that cycle. Next cycle exccode_o=5'h0C, pc_o=0xBFC00100, in_delay_o=0. stall_o=1 for 3 cycles, then IDLE.
- Priority: vec=6'b011010, in_delay=1, pc=0x80 → exccode_o=5'h0A (RI), in_delay_o=1, pc_o=0x80.
- Interrupt gating:
  - int_i[2]=1 with IM[12]=1, IE=1, EXL=0, valid=1, vec=6'b001000 → EXC_INT 5'h00 fires 3 cycles after the int_i edge (2 sync + FIRE).
  - Repeat with EXL=1 → no event.
- Interrupt waits on bubble: int pending, valid=0 for 4 cycles → exccode_o stays 5'h10. Valid rises → FIRE on the following cycle with that PC.
- ERET then immediate SYS: ERET in cycle N and SYS presented in N+1..N+3 → only EXC_ERET in N+1. SYS is taken only if still presented in N+4 (IDLE), firing in N+5.
- Async reset in HOLD: assert cpu_rst mid-HOLD → stall_o, busy_o and int_o drop to 0 without waiting for a clock edge. After release, a new OV event fires normally.
